// File: rtl/s_load_seq_pkg.sv
// Shared types for the S-register load sequencer: state encoding and output bundle.
// Latency: n/a (types and a pure decode function only).
// Backpressure: n/a.
package s_seq_pkg;

  // Default iteration-count width (max 2^CNT_W-1 iterations).
  localparam int DEF_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    ITER = 2'b10,
    DONE = 2'b11
  } state_t;

  // Registered Moore outputs; S_ld is gated by hold/abort after the register.
  typedef struct packed {
    logic sel;
    logic ld;
    logic busy;
    logic done;
  } seq_out_t;

  function automatic seq_out_t decode(state_t s);
    seq_out_t o;
    o = '0;
    case (s)
      LOAD:    begin o.sel = 1'b1; o.ld = 1'b1; o.busy = 1'b1; end
      ITER:    begin o.ld = 1'b1; o.busy = 1'b1; end
      DONE:    o.done = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/s_load_seq_if.sv
// Control-unit <-> sequencer bundle; master = control unit, slave = sequencer.
// Latency: n/a (wires only).
// Backpressure: hold stalls the sequencer; optional abort exists only with S_SEQ_ABORT_EN.
interface s_load_seq_if
  import s_seq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) ();
  logic             start;
  logic [CNT_W-1:0] count;
  logic             hold;
`ifdef S_SEQ_ABORT_EN
  logic             abort;
`endif
  logic             S_Sel;
  logic             S_ld;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] iter;

`ifdef S_SEQ_ABORT_EN
  modport master (output start, count, hold, abort, input S_Sel, S_ld, busy, done, iter);
  modport slave  (input start, count, hold, abort, output S_Sel, S_ld, busy, done, iter);
`else
  modport master (output start, count, hold, input S_Sel, S_ld, busy, done, iter);
  modport slave  (input start, count, hold, output S_Sel, S_ld, busy, done, iter);
`endif
endinterface

// File: rtl/s_iter_cnt.sv
// Loadable CNT_W-bit down counter holding the remaining iteration count.
// Latency: load/dec visible on the cycle after the edge; clear wins over load over dec.
// Backpressure: hold freezes the value; it never decrements below zero.
module s_iter_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  input  logic             hold,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);
  logic [CNT_W-1:0] cnt_q;

  // Counter register: synchronous clear, load on accepted start, saturating decrement.
  always_ff @(posedge clk) begin
    if (!reset)                            cnt_q <= '0;
    else if (clear)                        cnt_q <= '0;
    else if (load)                         cnt_q <= load_val;
    else if (dec && !hold && cnt_q != '0)  cnt_q <= cnt_q - CNT_W'(1);
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);
endmodule

// File: rtl/s_load_seq.sv
// S-mux/S-register sequencer: one DS load then count recirculations of S_in. Optional abort: S_SEQ_ABORT_EN.
// Latency: start accepted at edge k -> LOAD k+1, ITER k+2..k+1+count, done pulse at k+2+count.
// Backpressure: hold stalls LOAD/ITER one cycle per hold cycle with S_ld suppressed; start ignored while busy.
module s_load_seq
  import s_seq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        reset,
  s_load_seq_if.slave bus
);
  state_t           state;
  state_t           state_nx;
  seq_out_t         outs;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             cnt_one;
  logic             in_seq;
  logic             accept;
  logic             abort_act;

  assign in_seq  = (state == LOAD) || (state == ITER);
  assign accept  = ((state == IDLE) || (state == DONE)) && bus.start;
  assign cnt_one = (cnt == CNT_W'(1));

`ifdef S_SEQ_ABORT_EN
  assign abort_act = bus.abort && in_seq;
`else
  assign abort_act = 1'b0;
`endif

  s_iter_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (abort_act),
    .load     (accept),
    .load_val (bus.count),
    .dec      ((state == ITER) && !abort_act),
    .hold     (bus.hold),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // Next-state selection; abort beats hold, hold freezes LOAD/ITER only.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.start) state_nx = LOAD;
      LOAD: begin
        if (abort_act)      state_nx = IDLE;
        else if (!bus.hold) state_nx = cnt_zero ? DONE : ITER;
      end
      ITER: begin
        if (abort_act)               state_nx = IDLE;
        else if (!bus.hold && cnt_one) state_nx = DONE;
      end
      DONE:    state_nx = bus.start ? LOAD : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register with outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      outs  <= '0;
    end else begin
      state <= state_nx;
      outs  <= decode(state_nx);
    end
  end

  assign bus.S_Sel = outs.sel;
  assign bus.S_ld  = outs.ld && !bus.hold && !abort_act;
  assign bus.busy  = outs.busy;
  assign bus.done  = outs.done;
  assign bus.iter  = cnt;
endmodule

// File: tb/tb_s_load_seq.sv
// Self-checking bench: directed test-plan steps then random traffic against a schedule-queue model.
// Latency: n/a.
// Backpressure: exercises hold, start-while-busy, mid-sequence reset and (if enabled) abort.
module tb_s_load_seq;
  import s_seq_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  s_load_seq_if #(.CNT_W(4)) bus ();

  s_load_seq #(.CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // One expected cycle of a sequence; busy entries are the ones hold can stretch.
  typedef struct {
    logic       sel;
    logic       ld;
    logic       busy;
    logic       done;
    logic [3:0] iter;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   ld_seen = 0;
  int   done_seen = 0;

  // A sequence of n iterations is: one DS load, n recirculations counting n..1, one done cycle.
  task automatic push_seq(input logic [3:0] n);
    q.push_back('{sel: 1'b1, ld: 1'b1, busy: 1'b1, done: 1'b0, iter: n});
    for (int k = 0; k < int'(n); k++)
      q.push_back('{sel: 1'b0, ld: 1'b1, busy: 1'b1, done: 1'b0, iter: 4'(int'(n) - k)});
    q.push_back('{sel: 1'b0, ld: 1'b0, busy: 1'b0, done: 1'b1, iter: 4'd0});
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the model on the edge.
  task automatic cyc(input logic st, input logic [3:0] cn, input logic hd,
                     input logic ab, input logic rs);
    exp_t e;
    logic ab_v;
    reset     = rs;
    bus.start = st;
    bus.count = cn;
    bus.hold  = hd;
`ifdef S_SEQ_ABORT_EN
    bus.abort = ab;
    ab_v      = ab;
`else
    ab_v      = 1'b0 & ab;
`endif
    @(negedge clk);
    if (q.size() > 0) e = q[0];
    else e = '{sel: 1'b0, ld: 1'b0, busy: 1'b0, done: 1'b0, iter: 4'd0};
    check("S_Sel", {7'd0, bus.S_Sel}, {7'd0, e.sel});
    check("S_ld",  {7'd0, bus.S_ld},  {7'd0, e.ld & ~hd & ~ab_v});
    check("busy",  {7'd0, bus.busy},  {7'd0, e.busy});
    check("done",  {7'd0, bus.done},  {7'd0, e.done});
    check("iter",  {4'd0, bus.iter},  {4'd0, e.iter});
    if (bus.S_ld === 1'b1) ld_seen++;
    if (bus.done === 1'b1) done_seen++;
    @(posedge clk);
    if (!rs) q.delete();
    else if (q.size() == 0) begin
      if (st) push_seq(cn);
    end else if (q[0].busy) begin
      if (ab_v) q.delete();
      else if (!hd) void'(q.pop_front());
    end else begin
      void'(q.pop_front());
      if (st) push_seq(cn);
    end
    #1;
  endtask

  initial begin
    logic rs, st, hd, ab;
    logic [3:0] cn;

    // Reset held low for two cycles with start asserted.
    reset = 1'b0; bus.start = 1'b1; bus.count = 4'd5; bus.hold = 1'b0;
`ifdef S_SEQ_ABORT_EN
    bus.abort = 1'b0;
`endif
    @(posedge clk); #1;
    cyc(1, 4'd5, 0, 0, 0);
    cyc(1, 4'd5, 0, 0, 0);

    // Basic sequence, count=3: 4 S_ld pulses and one done pulse.
    ld_seen = 0; done_seen = 0;
    cyc(1, 4'd3, 0, 0, 1);
    for (int i = 0; i < 6; i++) cyc(0, 4'd9, 0, 0, 1);
    check("basic_ld_pulses", 8'(ld_seen), 8'd4);
    check("basic_done_pulses", 8'(done_seen), 8'd1);

    // count=0: one LOAD then done.
    ld_seen = 0;
    cyc(1, 4'd0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 4'd0, 0, 0, 1);
    check("zero_ld_pulses", 8'(ld_seen), 8'd1);

    // Hold for two cycles during the first ITER of a count=2 sequence.
    ld_seen = 0;
    cyc(1, 4'd2, 0, 0, 1);
    cyc(0, 4'd2, 0, 0, 1);
    cyc(0, 4'd2, 1, 0, 1);
    cyc(0, 4'd2, 1, 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 4'd2, 0, 0, 1);
    check("hold_ld_pulses", 8'(ld_seen), 8'd3);

    // Back-to-back with start held high; starts while busy are ignored.
    cyc(1, 4'd1, 0, 0, 1);
    cyc(1, 4'd7, 0, 0, 1);
    cyc(1, 4'd7, 0, 0, 1);
    cyc(1, 4'd2, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 4'd9, 0, 0, 1);
    for (int i = 0; i < 14; i++) cyc(0, 4'd0, 0, 0, 1);

    // Reset mid-sequence while iter=5: no done pulse.
    done_seen = 0;
    cyc(1, 4'd7, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 4'd7, 0, 0, 1);
    cyc(0, 4'd7, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 4'd7, 0, 0, 1);
    check("reset_no_done", 8'(done_seen), 8'd0);

`ifdef S_SEQ_ABORT_EN
    // Abort in the same position, with hold also high to show abort wins.
    done_seen = 0;
    cyc(1, 4'd7, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 4'd7, 0, 0, 1);
    cyc(0, 4'd7, 1, 1, 1);
    for (int i = 0; i < 3; i++) cyc(0, 4'd7, 0, 0, 1);
    check("abort_no_done", 8'(done_seen), 8'd0);
`endif

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rs = ($urandom_range(0, 59) != 0);
      st = ($urandom_range(0, 2) == 0);
      cn = 4'($urandom_range(0, 15));
      hd = ($urandom_range(0, 3) == 0);
`ifdef S_SEQ_ABORT_EN
      ab = ($urandom_range(0, 19) == 0);
`else
      ab = 1'b0;
`endif
      cyc(st, cn, hd, ab, rs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/s_load_seq.md
# s_load_seq

Sequencer that drives the S-register input select (S_Sel) and S-register load enable of the 16-bit RISC datapath for iterative operations. It loads the S register once from DS, then recirculates S_in through the datapath for a programmed number of iterations, for example multi-bit shifts or rotates. It sits between the control unit, which issues start/count, and the S-mux/S-register pair, and reports busy/done back to the control unit.

## Interface
- CNT_W, 4, width of the iteration count; maximum iterations 2^CNT_W-1
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-low reset (reset==0 clears the block on the rising edge of clk)
- start  input  1  request a new sequence; sampled only in IDLE or DONE
- count  input  CNT_W  number of recirculate iterations; captured with an accepted start
- hold  input  1  stall: freezes state and counter, suppresses S_ld
- S_Sel  output  1  mux select: 1 selects DS, 0 selects S_in
- S_ld  output  1  S-register load enable
- busy  output  1  high in LOAD and ITER
- done  output  1  one-cycle completion pulse
- iter  output  CNT_W  remaining iterations (counter value)

## Operation
- Moore FSM with 4 states: IDLE, LOAD, ITER, DONE. Outputs are decoded from the registered state and counter only, except for hold gating of S_ld.
- IDLE: S_Sel=0, S_ld=0, busy=0, done=0. If start=1, then cnt<=count and the next state is LOAD.
- LOAD: S_Sel=1, S_ld=!hold, busy=1. If hold=1, stay in LOAD. Otherwise go to ITER if cnt!=0, else go to DONE.
- ITER: S_Sel=0, S_ld=!hold, busy=1. If hold=1, the state and cnt are frozen. Otherwise cnt<=cnt-1, and when cnt==1 the next state is DONE.
- DONE: done=1, busy=0, S_Sel=0, S_ld=0. If start=1, capture count and go to LOAD (back-to-back sequences). Otherwise go to IDLE.
- start in LOAD/ITER is ignored. count is not re-sampled mid-sequence.
- iter mirrors cnt. It is 0 in IDLE/DONE after a completed sequence.
- The counter never wraps: a decrement occurs only in ITER with cnt>=1.

## Timing
- Reset values: state=IDLE, cnt=0, S_Sel=0, S_ld=0, busy=0, done=0, iter=0.
- Reset asserted mid-sequence forces IDLE on the next edge. No done pulse is produced.
- With no hold, a sequence accepted at edge k has:
  - LOAD in cycle k+1,
  - ITER in cycles k+2 .. k+1+count,
  - DONE in cycle k+2+count.
- Total S_ld pulses per sequence = 1+count. Latency from start to done = count+2 cycles.
- Each hold cycle in LOAD/ITER adds exactly one cycle of latency and produces no S_ld.
- When hold and start coincide in DONE, start wins: hold has no effect outside LOAD/ITER.

## Configuration
- Macro S_SEQ_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - When abort=1 in LOAD or ITER, S_ld is forced 0 in that cycle, the next state is IDLE and cnt<=0. No done pulse is produced.
  - abort has priority over hold. abort is ignored in IDLE/DONE.
- Undefined: there is no abort port, and a sequence always runs to DONE unless reset is asserted.

## Structure
- Shared package s_seq_pkg:
  - state encoding constants IDLE=2'b00, LOAD=2'b01, ITER=2'b10, DONE=2'b11,
  - default CNT_W=4.
- One sub-module, s_iter_cnt: a loadable CNT_W-bit down counter with load, dec, hold inputs and a zero flag. The FSM and output decode stay in s_load_seq.

## Test plan
- Reset: hold reset=0 for 2 cycles with start=1 -> all outputs 0, state IDLE. Release reset -> a start accepted on the next edge gives LOAD.
- Basic sequence, count=3, hold=0: start pulse -> S_Sel=1,S_ld=1 for 1 cycle; then S_Sel=0,S_ld=1 for 3 cycles with iter 3,2,1; then done=1 for 1 cycle at start+5.
- count=0: start -> one LOAD cycle (S_Sel=1,S_ld=1), then done the next cycle. Exactly 1 S_ld pulse.
- Hold: count=2, hold=1 for 2 cycles during the first ITER cycle -> S_ld=0 and iter stays 2 during hold. Total S_ld pulses=3 and done arrives 2 cycles late.
- Back-to-back: start=1 held through DONE, with count=1 then count=2 -> second LOAD directly follows DONE, and start pulses during busy are ignored.
- Reset/abort mid-sequence: reset=0 during ITER with iter=5 -> IDLE and iter=0 next cycle, no done. With S_SEQ_ABORT_EN, abort=1 in the same situation -> S_ld=0 that cycle, IDLE next cycle, no done.
